vec_chunk_buffer: RTL and testbench
===================================

// Module: vec_chunk_buffer
// PURPOSE
//  Ping-pong input-vector buffer that sits directly upstream of the matrix-vector product stage.
//  - Accepts int8 activations serially.
//  - Assembles each full InVecLength vector in one of two banks.
//  - Serves the vector as WorkingRegs-wide chunks on the consumer's request pulses.
//  - Lets the consumer re-read the same vector once per output row.
//  - The next vector fills the other bank while the current one is being read.
// PARAMETERS
//  InVecLength  16  elements per input vector; must be a multiple of WorkingRegs
//  WorkingRegs  4   elements per chunk (lanes of out_data)
//  (derived) Chunks = InVecLength/WorkingRegs
// PORTS
//  clk_in             in   1                 clock, all logic on rising edge
//  rst_n_in           in   1                 synchronous reset, active-low
//  wr_valid_in        in   1                 wr_data_in holds a valid element
//  wr_data_in         in   8 (signed)        incoming element, vector order 0..InVecLength-1
//  wr_ready_out       in/out: out 1          buffer can accept an element this cycle
//  req_chunk_in       in   1                 advance read pointer to next chunk
//  req_chunk_ptr_rst  in   1                 rewind read pointer to chunk 0 (row restart)
//  vec_done_in        in   1                 consumer finished with current vector; release bank
//  out_data           out  [WorkingRegs-1:0][7:0] signed  current chunk of read bank
//  out_data_ready     out  1                 read bank holds a complete vector
//  err_underflow_out  out  1                 sticky: vec_done_in seen with no full read bank
// BEHAVIOUR
//  State: 2 banks of InVecLength x 8b flops, bank_full[1:0], wr_bank, wr_idx, rd_bank, rd_chunk.
//  Reset (rst_n_in=0 at edge):
//   - Bank contents, bank_full, wr_bank, rd_bank, wr_idx, rd_chunk and err_underflow_out go to 0.
//   - Outputs: wr_ready_out=1, out_data=0, out_data_ready=0.
//   - Reset mid-vector discards partial and full vectors alike.
//  Write side:
//   - wr_ready_out = ~bank_full[wr_bank], combinational from registers.
//   - Element accepted when wr_valid_in & wr_ready_out.
//   - Accepted element goes to bank[wr_bank][wr_idx], and wr_idx increments.
//   - On the accept with wr_idx==InVecLength-1: bank_full[wr_bank]<=1, wr_bank toggles, wr_idx<=0.
//   - wr_valid_in while wr_ready_out=0: data is dropped and no state changes (upstream must hold).
//  Read side:
//   - out_data lane i = bank[rd_bank][rd_chunk*WorkingRegs+i], a combinational mux of registered state.
//   - Zero added latency: a pointer change at edge N is visible on out_data after edge N.
//   - out_data_ready = bank_full[rd_bank].
//   - req_chunk_ptr_rst (priority): rd_chunk<=0.
//   - Else req_chunk_in: rd_chunk<=rd_chunk+1, wrapping Chunks-1 -> 0.
//   - Requests are honoured even when out_data_ready=0 (pointer only); consumer must gate on ready.
//   - vec_done_in with bank_full[rd_bank]=1: bank_full[rd_bank]<=0, rd_bank toggles, rd_chunk<=0.
//     vec_done_in takes priority over req_chunk_in and req_chunk_ptr_rst in the same cycle.
//   - vec_done_in with bank_full[rd_bank]=0: ignored except err_underflow_out<=1 (cleared only by reset).
//  Simultaneous events:
//   - Write completion into wr_bank and vec_done_in on rd_bank in the same cycle both take effect.
//   - When both banks are full, wr_ready_out=0 until the vec_done_in edge; wr_ready_out=1 the cycle after.
//   - A bank completed in cycle N makes out_data_ready=1 in cycle N+1 when it is rd_bank.
//  Chunks==1 (WorkingRegs==InVecLength): rd_chunk is constant 0 and requests are no-ops.
// TESTING
//  1 Reset: drive rst_n_in=0 for 2 cycles.
//    -> wr_ready_out=1, out_data_ready=0, out_data=0, err_underflow_out=0.
//  2 Fill/read (16/4): write 1..16 back-to-back.
//    -> out_data_ready=1 one cycle after the 16th accept; out_data={4,3,2,1} (lane0=1).
//    -> 3 req_chunk_in pulses give lane0=5, 9, 13; a 4th pulse wraps to lane0=1.
//  3 Row restart: advance to chunk 2 (lane0=9), pulse req_chunk_ptr_rst together with req_chunk_in.
//    -> lane0=1 next cycle.
//  4 Ping-pong/backpressure:
//    - Write vector A (1..16) then B (101..116) -> wr_ready_out=0 after the 32nd accept.
//    - Further writes are dropped.
//    - Pulse vec_done_in -> out_data lane0=101, out_data_ready stays 1, wr_ready_out=1 next cycle.
//  5 Simultaneous: the last element of B is accepted in the same cycle as vec_done_in for A.
//    -> rd_bank = B with out_data_ready=1 next cycle, wr_bank back on A's bank, empty.
//  6 Underflow/reset mid-op: pulse vec_done_in while empty -> err_underflow_out=1 and sticks.
//    -> Then write 7 elements and assert reset -> all flags 0, next 16 writes form a clean vector.

Source files
------------

// File: rtl/vec_chunk_buffer.sv
// Ping-pong int8 vector buffer: serial fill into one bank while the other is served as WorkingRegs-wide chunks.
// Zero-latency read mux; writer is held off (wr_ready_out=0) only while both banks hold unread vectors.
module vec_chunk_buffer #(
    parameter int InVecLength = 16,
    parameter int WorkingRegs = 4
) (
    input  logic                               clk_in,
    input  logic                               rst_n_in,
    input  logic                               wr_valid_in,
    input  logic signed [7:0]                  wr_data_in,
    output logic                               wr_ready_out,
    input  logic                               req_chunk_in,
    input  logic                               req_chunk_ptr_rst,
    input  logic                               vec_done_in,
    output logic signed [WorkingRegs-1:0][7:0] out_data,
    output logic                               out_data_ready,
    output logic                               err_underflow_out
);

    localparam int Chunks = InVecLength / WorkingRegs;
    localparam int CW     = (Chunks > 1) ? $clog2(Chunks) : 1;
    localparam int IW     = (InVecLength > 1) ? $clog2(InVecLength) : 1;

    logic [1:0][InVecLength-1:0][7:0] bank_q, bank_d;
    logic [1:0]                       full_q, full_d;
    logic                             wr_bank_q, wr_bank_d;
    logic                             rd_bank_q, rd_bank_d;
    logic [IW-1:0]                    wr_idx_q, wr_idx_d;
    logic [CW-1:0]                    rd_chunk_q, rd_chunk_d;
    logic                             err_q, err_d;

    logic wr_accept;
    logic wr_last;
    logic rd_full;
    logic done_ok;

    assign wr_ready_out      = ~full_q[wr_bank_q];
    assign wr_accept         = wr_valid_in & wr_ready_out;
    assign wr_last           = (wr_idx_q == IW'(InVecLength - 1));
    assign rd_full           = full_q[rd_bank_q];
    assign done_ok           = vec_done_in & rd_full;
    assign out_data_ready    = rd_full;
    assign err_underflow_out = err_q;

    always_comb begin
        bank_d     = bank_q;
        full_d     = full_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        wr_idx_d   = wr_idx_q;
        rd_chunk_d = rd_chunk_q;
        err_d      = err_q | (vec_done_in & ~rd_full);

        if (wr_accept) begin
            bank_d[wr_bank_q][wr_idx_q] = wr_data_in;
            if (wr_last) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
                wr_idx_d          = '0;
            end else begin
                wr_idx_d = wr_idx_q + IW'(1);
            end
        end

        // The write bank is never full on accept and the read bank is full on release,
        // so these two full-flag updates always touch different banks.
        if (done_ok) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
            rd_chunk_d        = '0;
        end else if (req_chunk_ptr_rst) begin
            rd_chunk_d = '0;
        end else if (req_chunk_in) begin
            rd_chunk_d = (rd_chunk_q == CW'(Chunks - 1)) ? '0 : rd_chunk_q + CW'(1);
        end
    end

    always_comb begin
        out_data = '0;
        for (int i = 0; i < WorkingRegs; i++) begin
            out_data[i] = bank_q[rd_bank_q][IW'(int'(rd_chunk_q) * WorkingRegs + i)];
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            bank_q     <= '0;
            full_q     <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr_idx_q   <= '0;
            rd_chunk_q <= '0;
            err_q      <= 1'b0;
        end else begin
            bank_q     <= bank_d;
            full_q     <= full_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            wr_idx_q   <= wr_idx_d;
            rd_chunk_q <= rd_chunk_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_vec_chunk_buffer.sv
// Self-checking bench for vec_chunk_buffer (16 elements, 4 lanes): directed scenarios plus a randomized run
// against a queue-of-vectors reference model.
module tb_vec_chunk_buffer;

    logic             clk_in = 1'b0;
    logic             rst_n_in;
    logic             wr_valid_in;
    logic [7:0]       wr_data_in;
    logic             wr_ready_out;
    logic             req_chunk_in;
    logic             req_chunk_ptr_rst;
    logic             vec_done_in;
    logic [3:0][7:0]  out_data;
    logic             out_data_ready;
    logic             err_underflow_out;

    int checks   = 0;
    int failures = 0;

    vec_chunk_buffer #(.InVecLength(16), .WorkingRegs(4)) dut (
        .clk_in            (clk_in),
        .rst_n_in          (rst_n_in),
        .wr_valid_in       (wr_valid_in),
        .wr_data_in        (wr_data_in),
        .wr_ready_out      (wr_ready_out),
        .req_chunk_in      (req_chunk_in),
        .req_chunk_ptr_rst (req_chunk_ptr_rst),
        .vec_done_in       (vec_done_in),
        .out_data          (out_data),
        .out_data_ready    (out_data_ready),
        .err_underflow_out (err_underflow_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle;
        wr_valid_in       = 1'b0;
        wr_data_in        = 8'd0;
        req_chunk_in      = 1'b0;
        req_chunk_ptr_rst = 1'b0;
        vec_done_in       = 1'b0;
    endtask

    task automatic do_reset;
        idle();
        rst_n_in = 1'b0;
        tick();
        tick();
        rst_n_in = 1'b1;
    endtask

    task automatic wr(input logic [7:0] d);
        wr_valid_in = 1'b1;
        wr_data_in  = d;
        tick();
        wr_valid_in = 1'b0;
    endtask

    task automatic req_pulse(input logic ptr_rst);
        req_chunk_in      = 1'b1;
        req_chunk_ptr_rst = ptr_rst;
        tick();
        req_chunk_in      = 1'b0;
        req_chunk_ptr_rst = 1'b0;
    endtask

    task automatic done_pulse;
        vec_done_in = 1'b1;
        tick();
        vec_done_in = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        checks += 4;
        if (wr_ready_out !== 1'b1) begin failures++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready_out); end
        if (out_data_ready !== 1'b0) begin failures++; $display("FAIL reset_out_ready got=%b exp=0", out_data_ready); end
        if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        if (err_underflow_out !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_underflow_out); end
    endtask

    task automatic test_fill_read;
        logic [7:0] exp_l0 [4];
        exp_l0 = '{8'd5, 8'd9, 8'd13, 8'd1};
        do_reset();
        for (int i = 1; i <= 15; i++) wr(8'(i));
        checks++;
        if (out_data_ready !== 1'b0) begin failures++; $display("FAIL fill_early_ready got=%b exp=0", out_data_ready); end
        wr(8'd16);
        checks += 3;
        if (out_data_ready !== 1'b1) begin failures++; $display("FAIL fill_ready got=%b exp=1", out_data_ready); end
        if (out_data !== {8'd4, 8'd3, 8'd2, 8'd1}) begin failures++; $display("FAIL fill_chunk0 got=%h exp=04030201", out_data); end
        if (wr_ready_out !== 1'b1) begin failures++; $display("FAIL fill_wr_ready got=%b exp=1", wr_ready_out); end
        for (int k = 0; k < 4; k++) begin
            req_pulse(1'b0);
            checks++;
            if (out_data[0] !== exp_l0[k]) begin
                failures++; $display("FAIL chunk_step%0d got=%0d exp=%0d", k, out_data[0], exp_l0[k]);
            end
        end
    endtask

    task automatic test_row_restart;
        req_pulse(1'b0);
        req_pulse(1'b0);
        checks++;
        if (out_data[0] !== 8'd9) begin failures++; $display("FAIL restart_pre got=%0d exp=9", out_data[0]); end
        req_pulse(1'b1);
        checks += 2;
        if (out_data[0] !== 8'd1) begin failures++; $display("FAIL restart_lane0 got=%0d exp=1", out_data[0]); end
        if (out_data_ready !== 1'b1) begin failures++; $display("FAIL restart_ready got=%b exp=1", out_data_ready); end
    endtask

    task automatic test_pingpong;
        do_reset();
        for (int i = 1; i <= 16; i++) wr(8'(i));
        for (int i = 101; i <= 116; i++) wr(8'(i));
        checks++;
        if (wr_ready_out !== 1'b0) begin failures++; $display("FAIL pp_backpressure got=%b exp=0", wr_ready_out); end
        wr(8'd55);
        wr(8'd56);
        checks += 2;
        if (wr_ready_out !== 1'b0) begin failures++; $display("FAIL pp_hold got=%b exp=0", wr_ready_out); end
        if (out_data[0] !== 8'd1) begin failures++; $display("FAIL pp_a_lane0 got=%0d exp=1", out_data[0]); end
        done_pulse();
        checks += 3;
        if (out_data[0] !== 8'd101) begin failures++; $display("FAIL pp_b_lane0 got=%0d exp=101", out_data[0]); end
        if (out_data_ready !== 1'b1) begin failures++; $display("FAIL pp_b_ready got=%b exp=1", out_data_ready); end
        if (wr_ready_out !== 1'b1) begin failures++; $display("FAIL pp_release got=%b exp=1", wr_ready_out); end
        done_pulse();
        checks++;
        if (out_data_ready !== 1'b0) begin failures++; $display("FAIL pp_drained got=%b exp=0", out_data_ready); end
        for (int i = 201; i <= 216; i++) wr(8'(i));
        checks += 2;
        if (out_data_ready !== 1'b1) begin failures++; $display("FAIL pp_c_ready got=%b exp=1", out_data_ready); end
        if (out_data !== {8'd204, 8'd203, 8'd202, 8'd201}) begin
            failures++; $display("FAIL pp_c_chunk0 got=%h exp=cccbcac9", out_data);
        end
    endtask

    task automatic test_simultaneous;
        do_reset();
        for (int i = 1; i <= 16; i++) wr(8'(i));
        for (int i = 101; i <= 115; i++) wr(8'(i));
        vec_done_in = 1'b1;
        wr(8'd116);
        vec_done_in = 1'b0;
        checks += 3;
        if (out_data_ready !== 1'b1) begin failures++; $display("FAIL sim_ready got=%b exp=1", out_data_ready); end
        if (out_data[0] !== 8'd101) begin failures++; $display("FAIL sim_lane0 got=%0d exp=101", out_data[0]); end
        if (wr_ready_out !== 1'b1) begin failures++; $display("FAIL sim_wr_ready got=%b exp=1", wr_ready_out); end
        for (int i = 31; i <= 46; i++) wr(8'(i));
        checks++;
        if (wr_ready_out !== 1'b0) begin failures++; $display("FAIL sim_refill_full got=%b exp=0", wr_ready_out); end
        done_pulse();
        checks++;
        if (out_data !== {8'd34, 8'd33, 8'd32, 8'd31}) begin
            failures++; $display("FAIL sim_refill_chunk0 got=%h exp=2221201f", out_data);
        end
    endtask

    task automatic test_underflow_reset;
        do_reset();
        done_pulse();
        checks++;
        if (err_underflow_out !== 1'b1) begin failures++; $display("FAIL uf_set got=%b exp=1", err_underflow_out); end
        for (int i = 0; i < 3; i++) tick();
        for (int i = 1; i <= 7; i++) wr(8'(i));
        checks++;
        if (err_underflow_out !== 1'b1) begin failures++; $display("FAIL uf_sticky got=%b exp=1", err_underflow_out); end
        do_reset();
        checks += 4;
        if (err_underflow_out !== 1'b0) begin failures++; $display("FAIL uf_clear got=%b exp=0", err_underflow_out); end
        if (out_data_ready !== 1'b0) begin failures++; $display("FAIL uf_ready got=%b exp=0", out_data_ready); end
        if (wr_ready_out !== 1'b1) begin failures++; $display("FAIL uf_wr_ready got=%b exp=1", wr_ready_out); end
        if (out_data !== 32'h0) begin failures++; $display("FAIL uf_data got=%h exp=0", out_data); end
        for (int i = 11; i <= 26; i++) wr(8'(i));
        checks += 2;
        if (out_data_ready !== 1'b1) begin failures++; $display("FAIL uf_clean_ready got=%b exp=1", out_data_ready); end
        if (out_data !== {8'd14, 8'd13, 8'd12, 8'd11}) begin
            failures++; $display("FAIL uf_clean_chunk0 got=%h exp=0e0d0c0b", out_data);
        end
    endtask

    // Reference: completed vectors waiting to be consumed form a FIFO of at most two;
    // the head is what the reader sees, the partial queue is what the writer is building.
    typedef logic [7:0] vec_t [16];

    task automatic test_random;
        vec_t       done_q [$];
        logic [7:0] part_q [$];
        vec_t       v;
        int         chunk;
        logic       err;
        logic       acc, rel;
        int         shown;
        do_reset();
        chunk = 0;
        err   = 1'b0;
        shown = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            checks += 3;
            if (wr_ready_out !== (done_q.size() < 2)) begin
                failures++; if (shown++ < 10) $display("FAIL rnd_wr_ready cyc=%0d got=%b exp=%b", cyc, wr_ready_out, done_q.size() < 2);
            end
            if (out_data_ready !== (done_q.size() > 0)) begin
                failures++; if (shown++ < 10) $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, out_data_ready, done_q.size() > 0);
            end
            if (err_underflow_out !== err) begin
                failures++; if (shown++ < 10) $display("FAIL rnd_err cyc=%0d got=%b exp=%b", cyc, err_underflow_out, err);
            end
            if (done_q.size() > 0) begin
                for (int l = 0; l < 4; l++) begin
                    checks++;
                    if (out_data[l] !== done_q[0][chunk*4 + l]) begin
                        failures++;
                        if (shown++ < 10) $display("FAIL rnd_lane%0d cyc=%0d got=%0d exp=%0d", l, cyc, out_data[l], done_q[0][chunk*4 + l]);
                    end
                end
            end
            wr_valid_in       = ($urandom_range(0, 99) < 70);
            wr_data_in        = 8'($urandom);
            req_chunk_in      = ($urandom_range(0, 99) < 30);
            req_chunk_ptr_rst = ($urandom_range(0, 99) < 8);
            vec_done_in       = ($urandom_range(0, 99) < 7);

            acc = wr_valid_in && (done_q.size() < 2);
            rel = vec_done_in && (done_q.size() > 0);
            if (vec_done_in && done_q.size() == 0) err = 1'b1;
            if (rel) begin
                void'(done_q.pop_front());
                chunk = 0;
            end else if (req_chunk_ptr_rst) begin
                chunk = 0;
            end else if (req_chunk_in) begin
                chunk = (chunk + 1) % 4;
            end
            if (acc) begin
                part_q.push_back(wr_data_in);
                if (part_q.size() == 16) begin
                    for (int k = 0; k < 16; k++) v[k] = part_q[k];
                    done_q.push_back(v);
                    part_q.delete();
                end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        rst_n_in = 1'b0;
        idle();
        test_reset();
        test_fill_read();
        test_row_restart();
        test_pingpong();
        test_simultaneous();
        test_underflow_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
